// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and default register map constants for uart_tx_dma.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SEND, FINISH} dma_state_t;
  localparam logic [31:0] TX_DR_ADDR_DEF  = 32'd1020;
  localparam int          TX_FULL_BIT_DEF = 0;
endpackage

// File: rtl/byte_sel.sv
// byte_sel: picks byte idx_i of a 32-bit word, little-endian (idx 0 = bits 7:0).
module byte_sel (
  input  logic [31:0] word_i,
  input  logic [1:0]  idx_i,
  output logic [7:0]  byte_o
);
  assign byte_o = word_i[{idx_i, 3'b000} +: 8];
endmodule

// File: rtl/uart_tx_dma.sv
// uart_tx_dma: streams len bytes from word memory into the UART TX data register via a shared LSU.
// Optional UART_TX_DMA_ABORT_EN adds an abort input that ends a transfer early with a done pulse.
module uart_tx_dma
  import uart_pkg::*;
#(
  parameter logic [31:0] TX_DR_ADDR  = TX_DR_ADDR_DEF,
  parameter int          TX_FULL_BIT = TX_FULL_BIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] len,
  input  logic        core_req,
  input  logic [3:0]  uart_status,
  input  logic [31:0] mem_rdata,
`ifdef UART_TX_DMA_ABORT_EN
  input  logic        abort,
`endif
  output logic        dma_gnt,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done
);
  dma_state_t  state_q, state_d;
  logic [31:0] ptr_q, ptr_d, buf_q, buf_d;
  logic [15:0] rem_q, rem_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cur_byte;
  logic        can_send;

  byte_sel u_byte_sel (.word_i(buf_q), .idx_i(idx_q), .byte_o(cur_byte));

  assign busy     = state_q != IDLE;
  assign can_send = !core_req && !uart_status[TX_FULL_BIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      buf_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      buf_q   <= buf_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    buf_d     = buf_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    dma_gnt   = 1'b0;
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    done      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        ptr_d   = base_addr;
        rem_d   = len;
        state_d = len != 16'd0 ? FETCH : FINISH;
      end
      FETCH: if (!core_req) begin
        dma_gnt   = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = ptr_q;
        state_d   = CAPTURE;
      end
      CAPTURE: begin
        buf_d   = mem_rdata;
        idx_d   = 2'd0;
        state_d = SEND;
      end
      SEND: if (can_send) begin
        dma_gnt   = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = TX_DR_ADDR;
        mem_wdata = {24'b0, cur_byte};
        rem_d     = rem_q - 16'd1;
        idx_d     = idx_q + 2'd1;
        ptr_d     = (rem_q != 16'd1 && idx_q == 2'd3) ? ptr_q + 32'd1 : ptr_q;
        state_d   = rem_q == 16'd1 ? FINISH : idx_q == 2'd3 ? FETCH : SEND;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_TX_DMA_ABORT_EN
    // FINISH already pulses done, so abort only redirects the active states.
    if (abort && state_q != IDLE && state_q != FINISH) begin
      state_d   = FINISH;
      ptr_d     = ptr_q;
      buf_d     = buf_q;
      rem_d     = rem_q;
      idx_d     = idx_q;
      dma_gnt   = 1'b0;
      mem_addr  = '0;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      mem_wdata = '0;
    end
`endif
  end
endmodule

// File: tb/tb_uart_tx_dma.sv
// tb_uart_tx_dma: scoreboard bench; expected bytes/read addresses are queued at launch, a negedge monitor checks the LSU.
module tb_uart_tx_dma;
  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, core_req = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] len = '0;
  logic [3:0]  uart_status = '0;
  logic [31:0] mem_rdata;
  logic        dma_gnt, mem_rd_en, mem_wr_en, busy, done;
  logic [31:0] mem_addr, mem_wdata;
`ifdef UART_TX_DMA_ABORT_EN
  logic        abort = 1'b0;
`endif

  int tests = 0, fails = 0;
  int reads = 0, writes = 0, done_cnt = 0, cyc = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rd_q[$];
  int          wr_cyc[$];
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  uart_tx_dma dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .core_req(core_req), .uart_status(uart_status), .mem_rdata(mem_rdata),
`ifdef UART_TX_DMA_ABORT_EN
    .abort(abort),
`endif
    .dma_gnt(dma_gnt), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .busy(busy), .done(done)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Read data arrives one cycle after the read strobe; garbage otherwise.
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem_word(mem_addr) : 32'hDEADBEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string msg);
    tests++;
    fails++;
    $display("FAIL %s", msg);
  endtask

  always @(negedge clk) begin
    cyc++;
    chk("core_priority", {31'b0, dma_gnt & core_req}, 32'd0);
    if (!dma_gnt)
      chk("idle_bus", mem_addr | mem_wdata | {30'b0, mem_rd_en, mem_wr_en}, 32'd0);
    if (mem_rd_en) begin
      reads++;
      if (rd_q.size() == 0) flag($sformatf("extra_read: unexpected read of %h", mem_addr));
      else chk("read_addr", mem_addr, rd_q.pop_front());
    end
    if (mem_wr_en) begin
      writes++;
      wr_cyc.push_back(cyc);
      chk("write_when_full", {31'b0, uart_status[0]}, 32'd0);
      chk("write_addr", mem_addr, 32'd1020);
      if (exp_q.size() == 0) flag($sformatf("extra_write: unexpected byte %h", mem_wdata));
      else chk("write_data", mem_wdata, {24'b0, exp_q.pop_front()});
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] b, input logic [15:0] l);
    for (int i = 0; i < int'(l); i++) begin
      logic [31:0] w;
      w = mem_word(b + 32'(i / 4));
      exp_q.push_back(w[8*(i%4) +: 8]);
    end
    for (int k = 0; k < (int'(l) + 3) / 4; k++) rd_q.push_back(b + 32'(k));
    wr_cyc.delete();
    base_addr = b;
    len = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int k = 0;
    while (wr_cyc.size() < n && k < 500) begin
      tick();
      k++;
    end
    if (wr_cyc.size() < n) flag($sformatf("timeout waiting for %0d writes, saw %0d", n, wr_cyc.size()));
  endtask

  task automatic wait_done(input bit noise);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin
      if (noise) begin
        core_req = $urandom_range(0, 3) == 0;
        uart_status = 4'($urandom);
        uart_status[0] = $urandom_range(0, 3) == 0;
      end
      tick();
      n++;
    end
    core_req = 1'b0;
    uart_status = '0;
    if (done_cnt == d0) flag("timeout waiting for done");
  endtask

  task automatic drained();
    chk("pending_bytes", 32'(exp_q.size()), 32'd0);
    chk("pending_reads", 32'(rd_q.size()), 32'd0);
  endtask

  initial begin
    int r0, w0, d0, c0;
    tick();
    tick();
    chk("reset_outputs", {26'b0, busy, done, dma_gnt, mem_rd_en, mem_wr_en, |(mem_addr | mem_wdata)}, 32'd0);
    start = 1'b1;
    len = 16'd5;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("start_during_rst", {31'b0, busy}, 32'd0);
    tick();
    chk("start_during_rst_2", {31'b0, busy}, 32'd0);

    mem[32'h10] = 32'h44332211;
    mem[32'h11] = 32'h66550000;
    d0 = done_cnt;
    launch(32'h10, 16'd4);
    wait_done(1'b0);
    drained();
    wait_writes(4);
    if (wr_cyc.size() == 4) chk("consecutive_sends", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);
    tick();
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("idle_after_done", {30'b0, busy, done}, 32'd0);

    r0 = reads;
    w0 = writes;
    launch(32'h10, 16'd6);
    wait_done(1'b0);
    drained();
    chk("partial_reads", 32'(reads - r0), 32'd2);
    chk("partial_writes", 32'(writes - w0), 32'd6);

    launch(32'h20, 16'd4);
    wait_writes(1);
    core_req = 1'b1;
    repeat (5) tick();
    chk("core_stall_writes", 32'(wr_cyc.size()), 32'd1);
    core_req = 1'b0;
    wait_done(1'b0);
    drained();

    launch(32'h30, 16'd4);
    wait_writes(1);
    uart_status[0] = 1'b1;
    repeat (10) tick();
    chk("full_stall_writes", 32'(wr_cyc.size()), 32'd1);
    uart_status[0] = 1'b0;
    c0 = cyc;
    wait_done(1'b0);
    drained();
    if (wr_cyc.size() > 1) chk("full_release_cycle", 32'(wr_cyc[1]), 32'(c0 + 1));

    r0 = reads;
    w0 = writes;
    d0 = done_cnt;
    launch(32'h50, 16'd0);
    chk("len0_busy", {30'b0, busy, done}, 32'd3);
    tick();
    chk("len0_idle", {30'b0, busy, done}, 32'd0);
    chk("len0_done", 32'(done_cnt - d0), 32'd1);
    chk("len0_no_access", 32'(reads - r0 + writes - w0), 32'd0);

    launch(32'h60, 16'd8);
    wait_writes(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    exp_q.delete();
    rd_q.delete();
    r0 = reads;
    w0 = writes;
    d0 = done_cnt;
    repeat (20) tick();
    chk("rst_mid_quiet", 32'(reads - r0 + writes - w0 + done_cnt - d0), 32'd0);

`ifdef UART_TX_DMA_ABORT_EN
    d0 = done_cnt;
    launch(32'h70, 16'd8);
    wait_writes(2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(1'b0);
    tick();
    chk("abort_writes", 32'(wr_cyc.size()), 32'd2);
    chk("abort_done", 32'(done_cnt - d0), 32'd1);
    chk("abort_idle", {31'b0, busy}, 32'd0);
    exp_q.delete();
    rd_q.delete();
`endif

    for (int t = 0; t < 25; t++) begin
      logic [31:0] b;
      b = (t % 5 == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 3)) : $urandom;
      d0 = done_cnt;
      launch(b, 16'($urandom_range(1, 24)));
      wait_done(1'b1);
      tick();
      drained();
      chk("rand_done_once", 32'(done_cnt - d0), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_dma.md
UART_TX_DMA -- requirements
Module: uart_tx_dma

Interface
REQ-001 SHALL have parameter TX_DR_ADDR, default 32'd1020, LSU address of the UART TX data register.
REQ-002 SHALL have parameter TX_FULL_BIT, default 0, index of the TX-FIFO-full flag in uart_status.
REQ-003 SHALL have ports: clk  in  1  sole clock; rising edge active.
REQ-004 SHALL have ports: rst  in  1  synchronous reset, active-high.
REQ-005 SHALL have ports: start  in  1  one-cycle pulse that launches a transfer; ignored while busy.
REQ-006 SHALL have ports: base_addr  in  32  word address of the first source word; len  in  16  byte count.
REQ-007 SHALL have ports: core_req  in  1  core is using the LSU this cycle and has priority.
REQ-008 SHALL have ports: uart_status  in  4  UART status flags; mem_rdata  in  32  LSU read data.
REQ-009 SHALL have ports: dma_gnt  out  1  DMA drives the LSU this cycle; mem_addr  out  32; mem_rd_en  out  1; mem_wr_en  out  1; mem_wdata  out  32.
REQ-010 SHALL have ports: busy  out  1  transfer in progress; done  out  1  one-cycle completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, CAPTURE, SEND, FINISH.
REQ-012 IDLE: on start with len!=0, latch base_addr into word pointer, len into remaining count, go FETCH. start with len==0 SHALL go directly to FINISH.
REQ-013 FETCH: when core_req==0, assert dma_gnt, mem_rd_en=1, mem_addr=word pointer for exactly one cycle, go CAPTURE. Otherwise hold FETCH.
REQ-014 CAPTURE: latch mem_rdata (valid one cycle after mem_rd_en) into a 32-bit byte buffer, clear byte index to 0, go SEND.
REQ-015 SEND: a byte write SHALL occur only in a cycle with core_req==0 and uart_status[TX_FULL_BIT]==0. It SHALL assert dma_gnt, mem_wr_en=1, mem_addr=TX_DR_ADDR, mem_wdata={24'b0, selected byte}.
REQ-016 Bytes SHALL be sent little-endian: byte index 0 = buffer[7:0] through index 3 = buffer[31:24].
REQ-017 After each write, remaining SHALL decrement by 1. If remaining becomes 0, go FINISH. Else if byte index was 3, increment word pointer by 1 and go FETCH. Else increment byte index.
REQ-018 A final partial word SHALL send only the remaining bytes; unused upper bytes are never written.
REQ-019 FINISH: assert done for one cycle, go IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 When dma_gnt==0, mem_rd_en, mem_wr_en, mem_addr and mem_wdata SHALL be 0.
REQ-022 Core priority is absolute: DMA SHALL never drive the LSU in a cycle with core_req==1.
REQ-023 A TX-full flag or core_req in SEND SHALL stall without losing or repeating a byte.
REQ-024 Word pointer SHALL wrap modulo 2^32; len is capped at 65535 by width.

Reset
REQ-025 rst SHALL force IDLE and clear word pointer, remaining, byte index and buffer. Outputs SHALL be busy=0, done=0, dma_gnt=0, and all mem_* = 0 in the following cycle.
REQ-026 rst asserted mid-transfer SHALL abandon it with no done pulse and no further LSU access.
REQ-027 start coincident with rst SHALL be ignored.

Configuration
REQ-028 Macro UART_TX_DMA_ABORT_EN SHALL add input abort (1 bit).
REQ-029 With UART_TX_DMA_ABORT_EN, abort in any non-IDLE state SHALL go to FINISH next cycle and pulse done. The current-cycle LSU access is suppressed.
REQ-030 Without UART_TX_DMA_ABORT_EN, the abort port SHALL NOT exist, and transfers end only by completion or rst.

Structure
REQ-031 The state enum (dma_state_t) and the default TX_DR_ADDR/TX_FULL_BIT constants SHALL reside in package uart_pkg.
REQ-032 The byte selector SHALL be sub-module byte_sel (32-bit word, 2-bit index -> 8-bit byte). Everything else SHALL be flat.

Verification
REQ-033 base=0x10, len=4, word 0x44332211, core_req=0, FIFO never full -> writes 0x11,0x22,0x33,0x44 to address 1020 on consecutive SEND cycles, then one done pulse.
REQ-034 len=6, words at 0x10/0x11 = 0x44332211/0x66550000 -> bytes 0x11,0x22,0x33,0x44,0x00,0x00, with exactly 2 reads and 6 writes.
REQ-035 core_req held high for 5 cycles during SEND -> dma_gnt=0 and mem_* = 0 throughout, then resumption with the same pending byte.
REQ-036 uart_status[0]=1 for 10 cycles mid-word -> no write while full; the next byte is written the first cycle the flag is 0.
REQ-037 start with len=0 -> busy high 1 cycle, done pulse, no LSU access. rst during SEND -> busy=0 next cycle, no done.
REQ-038 With UART_TX_DMA_ABORT_EN, abort after the 2nd byte of len=8 -> exactly 2 writes, done pulse, IDLE.
